// File: rtl/data_path.sv
// Single-bus 32-bit datapath: R1-R3, PC, IR, MAR, MDR, Y and Zlow around one bus
// multiplexer and a combinational ALU (A = Y, B = bus).
module data_path (
    input  logic        clock,
    input  logic        clear,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        R2out,
    input  logic        R3out,
    input  logic        MDRin,
    input  logic        MD_read,
    input  logic        MDRout,
    input  logic        MARin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        Zlowin,
    input  logic        Zlowout,
    input  logic        IncPC,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] R1_q,
    output logic [31:0] R2_q,
    output logic [31:0] R3_q,
    output logic [31:0] PC_q,
    output logic [31:0] IR_q,
    output logic [31:0] MAR_q,
    output logic [31:0] MDR_q,
    output logic [31:0] Y_q,
    output logic [31:0] Zlow_q
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_NEG  = 4'h6,
        OP_SHR  = 4'h7,
        OP_SHRA = 4'h8,
        OP_ROR  = 4'h9,
        OP_SHL  = 4'hA,
        OP_ROL  = 4'hB
    } alu_op_e;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [63:0] rot_r;
    logic [63:0] rot_l;
    logic [31:0] zlow_d;
    logic [31:0] mdr_d;

    always_comb begin
        BusMuxOut = '0;
        if (MDRout)       BusMuxOut = MDR_q;
        else if (Zlowout) BusMuxOut = Zlow_q;
        else if (R3out)   BusMuxOut = R3_q;
        else if (R2out)   BusMuxOut = R2_q;
    end

    assign alu_a = Y_q;
    assign alu_b = BusMuxOut;
    assign shamt = alu_b[4:0];
    // Rotates via a doubled word so an amount of 0 falls out as A unchanged.
    assign rot_r = {alu_a, alu_a} >> shamt;
    assign rot_l = {alu_a, alu_a} << shamt;

    always_comb begin
        zlow_d = alu_b;
        if (IncPC) begin
            zlow_d = alu_b + 32'd1;
        end else begin
            case (IR_q[3:0])
                OP_ADD:  zlow_d = alu_a + alu_b;
                OP_SUB:  zlow_d = alu_a - alu_b;
                OP_AND:  zlow_d = alu_a & alu_b;
                OP_OR:   zlow_d = alu_a | alu_b;
                OP_XOR:  zlow_d = alu_a ^ alu_b;
                OP_NOT:  zlow_d = ~alu_b;
                OP_NEG:  zlow_d = '0 - alu_b;
                OP_SHR:  zlow_d = alu_a >> shamt;
                OP_SHRA: zlow_d = $unsigned($signed(alu_a) >>> shamt);
                OP_ROR:  zlow_d = rot_r[31:0];
                OP_SHL:  zlow_d = alu_a << shamt;
                OP_ROL:  zlow_d = rot_l[63:32];
                default: zlow_d = alu_b;
            endcase
        end
    end

    assign mdr_d = MD_read ? Mdatain : BusMuxOut;

    always_ff @(posedge clock) begin
        if (clear) begin
            R1_q   <= '0;
            R2_q   <= '0;
            R3_q   <= '0;
            PC_q   <= '0;
            IR_q   <= '0;
            MAR_q  <= '0;
            MDR_q  <= '0;
            Y_q    <= '0;
            Zlow_q <= '0;
        end else begin
            if (R1in)   R1_q   <= BusMuxOut;
            if (R2in)   R2_q   <= BusMuxOut;
            if (R3in)   R3_q   <= BusMuxOut;
            if (PCin)   PC_q   <= BusMuxOut;
            if (IRin)   IR_q   <= BusMuxOut;
            if (MARin)  MAR_q  <= BusMuxOut;
            if (MDRin)  MDR_q  <= mdr_d;
            if (Yin)    Y_q    <= BusMuxOut;
            if (Zlowin) Zlow_q <= zlow_d;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: queued expectations checked after each edge,
// table-driven ALU sweep, plus bus priority and clear sequences.
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear, R1in, R2in, R3in, R2out, R3out, MDRin, MD_read, MDRout;
    logic        MARin, PCin, IRin, Yin, Zlowin, Zlowout, IncPC;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, R1_q, R2_q, R3_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, Zlow_q;

    data_path dut (
        .clock(clock), .clear(clear), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .R2out(R2out), .R3out(R3out), .MDRin(MDRin), .MD_read(MD_read),
        .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zlowout(Zlowout), .IncPC(IncPC), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .R1_q(R1_q), .R2_q(R2_q), .R3_q(R3_q),
        .PC_q(PC_q), .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q),
        .Zlow_q(Zlow_q)
    );

    always #5 clock = ~clock;

    localparam logic [15:0] C_CLR   = 16'h0001, C_R1IN  = 16'h0002, C_R2IN  = 16'h0004,
                            C_R3IN  = 16'h0008, C_R2OUT = 16'h0010, C_R3OUT = 16'h0020,
                            C_MDRIN = 16'h0040, C_MDRD  = 16'h0080, C_MDROUT= 16'h0100,
                            C_MARIN = 16'h0200, C_PCIN  = 16'h0400, C_IRIN  = 16'h0800,
                            C_YIN   = 16'h1000, C_ZIN   = 16'h2000, C_ZOUT  = 16'h4000,
                            C_INC   = 16'h8000;
    localparam logic [15:0] C_LOADMD = C_MDRIN | C_MDRD;

    localparam int S_R1 = 0, S_R2 = 1, S_R3 = 2, S_PC = 3, S_IR = 4, S_MAR = 5,
                   S_MDR = 6, S_Y = 7, S_Z = 8, S_BUS = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] result;
    } alu_vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] obs(input int s);
        case (s)
            S_R1:    return R1_q;
            S_R2:    return R2_q;
            S_R3:    return R3_q;
            S_PC:    return PC_q;
            S_IR:    return IR_q;
            S_MAR:   return MAR_q;
            S_MDR:   return MDR_q;
            S_Y:     return Y_q;
            S_Z:     return Zlow_q;
            default: return BusMuxOut;
        endcase
    endfunction

    task automatic drive(input logic [15:0] c, input logic [31:0] md);
        {IncPC, Zlowout, Zlowin, Yin, IRin, PCin, MARin, MDRout,
         MD_read, MDRin, R3out, R2out, R3in, R2in, R1in, clear} = c;
        Mdatain = md;
    endtask

    task automatic check(input string n, input int sel, input logic [31:0] v);
        logic [31:0] act;
        act = obs(sel);
        n_checks++;
        if (act !== v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, v);
        end
    endtask

    task automatic expect_q(input string n, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = n; e.sel = sel; e.val = v;
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge, drain the scoreboard.
    task automatic cycle(input logic [15:0] c, input logic [31:0] md);
        exp_t e;
        @(negedge clock);
        drive(c, md);
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.sel, e.val);
        end
        drive('0, 32'h0);
    endtask

    task automatic comb_check(input string n, input logic [15:0] c, input logic [31:0] v);
        drive(c, 32'h0);
        #1;
        check(n, S_BUS, v);
        drive('0, 32'h0);
    endtask

    alu_vec_t vecs[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'h0, 32'h80000005};
        vecs[1]  = '{4'h1, 32'h7FFFFFFD};
        vecs[2]  = '{4'h2, 32'h00000000};
        vecs[3]  = '{4'h3, 32'h80000005};
        vecs[4]  = '{4'h4, 32'h80000005};
        vecs[5]  = '{4'h5, 32'hFFFFFFFB};
        vecs[6]  = '{4'h6, 32'hFFFFFFFC};
        vecs[7]  = '{4'h7, 32'h08000000};
        vecs[8]  = '{4'h8, 32'hF8000000};
        vecs[9]  = '{4'h9, 32'h18000000};
        vecs[10] = '{4'hA, 32'h00000010};
        vecs[11] = '{4'hB, 32'h00000018};
        vecs[12] = '{4'hC, 32'h00000004};
        vecs[13] = '{4'hD, 32'h00000004};
        vecs[14] = '{4'hE, 32'h00000004};
        vecs[15] = '{4'hF, 32'h00000004};

        drive('0, 32'h0);

        for (int s = 0; s < 9; s++) expect_q($sformatf("reset_reg%0d", s), s, 32'h0);
        cycle(C_CLR, 32'hDEADBEEF);
        check("reset_bus", S_BUS, 32'h0);

        // Register loads through MDR
        expect_q("ld_mdr_12", S_MDR, 32'h12);
        cycle(C_LOADMD, 32'h12);
        expect_q("ld_r2", S_R2, 32'h12);
        expect_q("ld_r2_mdr", S_MDR, 32'h12);
        cycle(C_MDROUT | C_R2IN, 32'h0);
        expect_q("ld_mdr_c", S_MDR, 32'hC);
        cycle(C_LOADMD, 32'hC);
        expect_q("ld_r3", S_R3, 32'hC);
        cycle(C_MDROUT | C_R3IN, 32'h0);
        expect_q("ld_mdr_18", S_MDR, 32'h18);
        cycle(C_LOADMD, 32'h18);
        expect_q("ld_r1", S_R1, 32'h18);
        cycle(C_MDROUT | C_R1IN, 32'h0);

        // Fetch
        expect_q("t0_zlow", S_Z, 32'h1);
        expect_q("t0_mar", S_MAR, 32'h0);
        cycle(C_INC | C_ZIN | C_MARIN, 32'h0);
        expect_q("t1_pc", S_PC, 32'h1);
        expect_q("t1_mdr", S_MDR, 32'hA);
        cycle(C_ZOUT | C_PCIN | C_LOADMD, 32'hA);
        expect_q("t2_ir", S_IR, 32'hA);
        cycle(C_MDROUT | C_IRIN, 32'h0);

        // SHL execute
        expect_q("shl_y", S_Y, 32'h12);
        cycle(C_R2OUT | C_YIN, 32'h0);
        expect_q("shl_zlow", S_Z, 32'h12000);
        cycle(C_R3OUT | C_ZIN, 32'h0);
        expect_q("shl_r1", S_R1, 32'h12000);
        cycle(C_ZOUT | C_R1IN, 32'h0);

        // Zlow read and reloaded in one cycle, fanned out to two registers
        expect_q("multi_r2", S_R2, 32'h12000);
        expect_q("multi_r3", S_R3, 32'h12000);
        expect_q("multi_zlow", S_Z, 32'h12);
        cycle(C_ZOUT | C_ZIN | C_R2IN | C_R3IN, 32'h0);

        // ALU sweep: Y = 0x80000001, B = R2 = 4
        cycle(C_LOADMD, 32'h4);
        cycle(C_MDROUT | C_R2IN, 32'h0);
        cycle(C_LOADMD, 32'h80000001);
        expect_q("sweep_y", S_Y, 32'h80000001);
        cycle(C_MDROUT | C_YIN, 32'h0);
        for (int i = 0; i < 16; i++) begin
            cycle(C_LOADMD, {28'h0, vecs[i].op});
            cycle(C_MDROUT | C_IRIN, 32'h0);
            expect_q($sformatf("alu_op%0h", vecs[i].op), S_Z, vecs[i].result);
            cycle(C_R2OUT | C_ZIN, 32'h0);
        end

        // Rotate by zero (empty bus) returns A; IncPC overrides SUB in IR
        cycle(C_LOADMD, 32'h9);
        cycle(C_MDROUT | C_IRIN, 32'h0);
        expect_q("ror_by_zero", S_Z, 32'h80000001);
        cycle(C_ZIN, 32'h0);
        cycle(C_LOADMD, 32'h1);
        cycle(C_MDROUT | C_IRIN, 32'h0);
        expect_q("incpc_override", S_Z, 32'h5);
        cycle(C_R2OUT | C_INC | C_ZIN, 32'h0);

        // Bus priority
        cycle(C_LOADMD, 32'h2);
        cycle(C_MDROUT | C_R2IN, 32'h0);
        cycle(C_LOADMD, 32'h3);
        cycle(C_MDROUT | C_R3IN, 32'h0);
        cycle(C_LOADMD, 32'h1);
        comb_check("bus_mdr_wins", C_MDROUT | C_R2OUT | C_R3OUT, 32'h1);
        comb_check("bus_r3_over_r2", C_R2OUT | C_R3OUT, 32'h3);
        comb_check("bus_zlow_over_r3", C_ZOUT | C_R3OUT | C_R2OUT, 32'h5);
        comb_check("bus_r2_only", C_R2OUT, 32'h2);
        comb_check("bus_idle", 16'h0, 32'h0);

        // Synchronous clear over fully loaded registers
        cycle(C_LOADMD, 32'h55);
        expect_q("preclr_pc", S_PC, 32'h55);
        expect_q("preclr_mar", S_MAR, 32'h55);
        cycle(C_MDROUT | C_R1IN | C_R2IN | C_R3IN | C_PCIN | C_IRIN | C_MARIN | C_YIN, 32'h0);
        for (int s = 0; s < 9; s++) expect_q($sformatf("clear_reg%0d", s), s, 32'h0);
        cycle(C_CLR | C_R1IN | C_LOADMD | C_ZIN | C_MDROUT, 32'hFFFF_FFFF);
        drive('0, 32'h0);
        #3;
        for (int s = 0; s < 10; s++) check($sformatf("postclr_hold%0d", s), s, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
